prog_counter: RTL and testbench

Runtime-programmable modulo counter, the parametrised successor of the fixed mod-M counter. Adds:
- configurable width;
- a run-time modulus register;
- synchronous load, enable and up/down direction;
- a periodic/one-shot mode FSM with start/stop and a done flag.

It sits beside timers and prescalers as the common tick/timebase generator. With default parameters and `en` tied high, it behaves exactly as a free-running mod-10 counter.

---
 rtl/prog_counter_pkg.sv | 19 +
 rtl/prog_counter_step.sv | 52 +++++
 rtl/prog_counter.sv | 108 ++++++++++
 tb/tb_prog_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
// Shared types and constants for the programmable modulo counter.
//   state_e : counter mode FSM states (IDLE, RUN, DONE)
// Optional feature macro used by the counter files: PROG_COUNTER_UPDOWN_EN.
package prog_counter_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/prog_counter_step.sv
// prog_counter_step
// Purely combinational next-count and wrap computation for one counter.
//   q      in  W  current count
//   term   in  W  terminal value (modulus - 1, W-bit wrap)
//   up     in  1  direction, 1 = up (ignored unless PROG_COUNTER_UPDOWN_EN)
//   q_next out W  count after one step
//   wrap   out 1  this step wraps
// Macro: PROG_COUNTER_UPDOWN_EN enables the down-count path.
module prog_counter_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] term,
    input  logic         up,
    output logic [W-1:0] q_next,
    output logic         wrap
);

`ifdef PROG_COUNTER_UPDOWN_EN
    always_comb begin
        q_next = q + W'(1);
        wrap   = 1'b0;
        if (up) begin
            // q above term (after a shrinking mod_wr or a load) wraps too
            if (q >= term) begin
                q_next = '0;
                wrap   = 1'b1;
            end
        end else begin
            if (q == '0 || q > term) begin
                q_next = term;
                wrap   = 1'b1;
            end else begin
                q_next = q - W'(1);
            end
        end
    end
`else
    logic unused_up;
    assign unused_up = up;

    always_comb begin
        q_next = q + W'(1);
        wrap   = 1'b0;
        if (q >= term) begin
            q_next = '0;
            wrap   = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/prog_counter.sv
// prog_counter
// Runtime-programmable modulo counter with periodic / one-shot modes.
//   clk, reset      clock, asynchronous active-high reset
//   en              count enable (one step per cycle in RUN)
//   up              direction (only with PROG_COUNTER_UPDOWN_EN)
//   load, load_val  synchronous load of q
//   mod_wr, mod_val write modulus register (0 encodes 2^W)
//   oneshot         1 = stop in DONE after a wrap
//   start, stop     mode control
//   q               current count
//   max_tick        wrap happens at the coming edge (combinational)
//   busy            state == RUN (registered)
//   done            one-shot completed (registered)
// Macro: PROG_COUNTER_UPDOWN_EN enables down counting.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int W          = 8,
    parameter int M_DEFAULT  = 10,
    parameter bit AUTO_START = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         mod_wr,
    input  logic [W-1:0] mod_val,
    input  logic         oneshot,
    input  logic         start,
    input  logic         stop,
    output logic [W-1:0] q,
    output logic         max_tick,
    output logic         busy,
    output logic         done
);

    // M_DEFAULT = 2^W truncates to 0, which is exactly the 2^W encoding
    localparam logic [W-1:0] M_RST    = W'(M_DEFAULT);
    localparam state_e       ST_RESET = AUTO_START ? ST_RUN : ST_IDLE;

    state_e         state;
    logic [W-1:0]   m_reg;
    logic [W-1:0]   term;
    logic [W-1:0]   q_next;
    logic [W-1:0]   restart_q;
    logic           wrap;
    logic           step_ok;

    assign term = m_reg - W'(1);

    prog_counter_step #(.W(W)) u_step (
        .q      (q),
        .term   (term),
        .up     (up),
        .q_next (q_next),
        .wrap   (wrap)
    );

`ifdef PROG_COUNTER_UPDOWN_EN
    assign restart_q = up ? '0 : term;
`else
    assign restart_q = '0;
`endif

    // load and stop both pre-empt the count step
    assign step_ok  = (state == ST_RUN) && en && !load && !stop;
    assign max_tick = !reset && step_ok && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            m_reg <= M_RST;
            state <= ST_RESET;
            busy  <= AUTO_START;
            done  <= 1'b0;
        end else begin
            // the step below still sees the old term this cycle
            if (mod_wr)
                m_reg <= mod_val;

            if (load) begin
                q <= load_val;
            end else if (stop) begin
                if (state == ST_RUN) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end else if (start && state != ST_RUN) begin
                if (state == ST_DONE) begin
                    q    <= restart_q;
                    done <= 1'b0;
                end
                state <= ST_RUN;
                busy  <= 1'b1;
            end else if (step_ok) begin
                q <= q_next;
                if (wrap && oneshot) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter
// Randomized and directed stimulus against a behavioural counter model;
// expected outputs are queued per cycle and checked by a separate monitor.
module tb_prog_counter;

    localparam int W   = 8;
    localparam int TOP = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, up, load, mod_wr, oneshot, start, stop;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] q;
    logic         max_tick, busy, done;

    prog_counter #(.W(W), .M_DEFAULT(10), .AUTO_START(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_val  (mod_val),
        .oneshot  (oneshot),
        .start    (start),
        .stop     (stop),
        .q        (q),
        .max_tick (max_tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit tick;
        bit busy;
        bit done;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   fails  = 0;

    // model: mode 0 idle, 1 run, 2 done; modulus kept as its true value 1..2^W
    int   mq;
    int   mmod;
    int   mmode;
    bit   mdone;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit dir_up();
`ifdef PROG_COUNTER_UPDOWN_EN
        return up;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit model_wraps(input int cq, input int m, input bit d);
        if (d) return cq >= m - 1;
        return (cq == 0) || (cq > m - 1);
    endfunction

    task automatic model_reset();
        mq    = 0;
        mmod  = 10;
        mmode = 1;
        mdone = 0;
    endtask

    // inputs already driven; queue expectations, then advance model at the edge
    task automatic step();
        exp_t e;
        bit   d, w, will_step;
        d = dir_up();
        w = model_wraps(mq, mmod, d);
        will_step = (mmode == 1) && en && !load && !stop;
        e.q    = mq;
        e.tick = will_step && w;
        e.busy = (mmode == 1);
        e.done = mdone;
        expq.push_back(e);
        @(posedge clk);
        if (load) begin
            mq = int'(load_val);
        end else if (stop) begin
            if (mmode == 1) mmode = 0;
        end else if (start && mmode != 1) begin
            if (mmode == 2) begin
                mq    = d ? 0 : mmod - 1;
                mdone = 0;
            end
            mmode = 1;
        end else if (will_step) begin
            if (w) begin
                mq = d ? 0 : mmod - 1;
                if (oneshot) begin
                    mmode = 2;
                    mdone = 1;
                end
            end else begin
                mq = d ? mq + 1 : mq - 1;
            end
        end
        if (mod_wr) mmod = (mod_val == 0) ? TOP : int'(mod_val);
        #1;
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("q", int'(q), e.q);
            chk("max_tick", int'(max_tick), int'(e.tick));
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
        end
    end

    task automatic clear_ctl();
        load = 0; mod_wr = 0; start = 0; stop = 0;
    endtask

    initial begin
        reset = 1; en = 0; up = 1; load = 0; mod_wr = 0; oneshot = 0;
        start = 0; stop = 0; load_val = '0; mod_val = '0;
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_tick", int'(max_tick), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();

        // free-running default mod-10
        en = 1; up = 1;
        repeat (25) step();

        // shrink modulus while at q=7
        while (mq != 7) step();
        mod_wr = 1; mod_val = 8'd4;
        step();
        mod_wr = 0;
        repeat (12) step();

        // modulus 2^W, then modulus 1
        mod_wr = 1; mod_val = 8'd0;
        step();
        mod_wr = 0;
        repeat (2 * TOP + 8) step();
        mod_wr = 1; mod_val = 8'd1;
        step();
        mod_wr = 0;
        repeat (10) step();

`ifdef PROG_COUNTER_UPDOWN_EN
        // down count with load and en together
        mod_wr = 1; mod_val = 8'd5;
        step();
        mod_wr = 0; up = 0; load = 1; load_val = 8'd2;
        step();
        load = 0;
        repeat (8) step();
        up = 1;
`endif

        // one-shot, restart, stop, stop+start
        mod_wr = 1; mod_val = 8'd3; load = 1; load_val = 8'd0;
        step();
        clear_ctl(); oneshot = 1;
        repeat (6) step();
        start = 1; step();
        start = 0; repeat (2) step();
        stop = 1; step();
        stop = 0; repeat (2) step();
        start = 1; stop = 1; step();
        stop = 0; step();
        start = 0; repeat (4) step();
        start = 1; step();
        start = 0; oneshot = 0;
        repeat (3) step();

        // async reset mid-run at q=6 with a non-default modulus
        mod_wr = 1; mod_val = 8'd12; load = 1; load_val = 8'd0;
        step();
        clear_ctl();
        repeat (6) step();
        chk("pre_reset_q", int'(q), 6);
        reset = 1;
        #1;
        chk("async_q", int'(q), 0);
        chk("async_tick", int'(max_tick), 0);
        chk("async_done", int'(done), 0);
        chk("async_busy", int'(busy), 1);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        model_reset();
        repeat (22) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            up       = $urandom_range(0, 1);
            load     = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom_range(0, TOP - 1));
            mod_wr   = ($urandom_range(0, 29) == 0);
            mod_val  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, TOP - 1))
                                                   : W'($urandom_range(0, 16));
            oneshot  = ($urandom_range(0, 4) == 0);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            step();
        end
        clear_ctl();
        @(negedge clk); #1;
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
